// File: rtl/sobel_pkg.sv
// Shared types and constants for the streaming Sobel edge detector.
package sobel_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned LAT    = 3;
    localparam int unsigned K_SIDE = 1;
    localparam int unsigned K_MID  = 2;

    typedef logic [PIX_W-1:0] win_elem_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Circular line buffer: one write and one read per cycle, read data one cycle later.
module sobel_line_buf #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned AW     = 11
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Read returns the old word when the same address is written this cycle.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector with run-time line length and threshold.
// Define SOBEL_PACK565_EN to emit each edge pixel as two gray RGB565 bytes.
module sobel_edge_stream
    import sobel_pkg::*;
#(
    parameter int unsigned DATA_W   = PIX_W,
    parameter int unsigned MAX_LINE = 2048,
    parameter int unsigned LINE_AW  = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start,
    input  logic [LINE_AW:0]    line_len,
    input  logic [DATA_W+2:0]   threshold,
    input  logic                pix_valid,
    input  logic [DATA_W-1:0]   pix_data,
    output logic                edge_valid,
    output logic [DATA_W-1:0]   edge_data,
    output logic                edge_sof,
    output logic                edge_eol,
    output logic                cfg_err
);

    localparam int unsigned MW     = DATA_W + 3;
    localparam int unsigned LW     = LINE_AW + 1;
    localparam int unsigned BUF_AW = clog2(MAX_LINE);
    localparam logic signed [MW-1:0] C_SIDE = MW'(K_SIDE);
    localparam logic signed [MW-1:0] C_MID  = MW'(K_MID);

    state_t               r_state, w_state_nxt;
    logic [LW-1:0]        r_w;
    logic [MW-1:0]        r_thr;
    logic [LINE_AW-1:0]   r_col;
    logic                 r_row1;
    logic                 r_first;
    logic                 w_acc, w_col_last, w_ok;
    logic                 w_len_lo, w_len_hi;
    logic [LW-1:0]        w_len_clamped;
    logic [BUF_AW-1:0]    w_addr;

    always_comb begin
        w_acc         = pix_valid && !frame_start && (r_state != ST_IDLE);
        w_col_last    = ({1'b0, r_col} == (r_w - LW'(1)));
        w_ok          = (r_state == ST_RUN) && (r_col >= LINE_AW'(2));
        w_addr        = BUF_AW'(r_col);
        w_len_lo      = line_len < LW'(3);
        w_len_hi      = line_len > LW'(MAX_LINE);
        w_len_clamped = line_len;
        if (w_len_lo)      w_len_clamped = LW'(3);
        else if (w_len_hi) w_len_clamped = LW'(MAX_LINE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (frame_start)
            w_state_nxt = ST_FILL;
        else if (w_acc && w_col_last && (r_state == ST_FILL) && r_row1)
            w_state_nxt = ST_RUN;
    end

    // Column/row tracking and per-frame configuration capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col   <= '0;
            r_row1  <= 1'b0;
            r_first <= 1'b0;
            r_w     <= '0;
            r_thr   <= '0;
            cfg_err <= 1'b0;
        end else if (frame_start) begin
            r_col   <= '0;
            r_row1  <= 1'b0;
            r_first <= 1'b0;
            r_w     <= w_len_clamped;
            r_thr   <= threshold;
            cfg_err <= w_len_lo || w_len_hi;
        end else if (w_acc) begin
            r_col <= w_col_last ? '0 : r_col + LINE_AW'(1);
            if (w_col_last) begin
                if (r_state == ST_FILL) begin
                    r_row1  <= 1'b1;
                    r_first <= r_row1;
                end else begin
                    r_first <= 1'b0;
                end
            end
        end
    end

    logic              r_s1_vld, r_s1_ok, r_s1_sof, r_s1_eol;
    win_elem_t         r_s1_pix;
    logic [BUF_AW-1:0] r_s1_addr;
    logic [DATA_W-1:0] w_row1, w_row2;

    always_ff @(posedge clk) begin
        if (!rst_n || frame_start) begin
            r_s1_vld  <= 1'b0;
            r_s1_ok   <= 1'b0;
            r_s1_sof  <= 1'b0;
            r_s1_eol  <= 1'b0;
            r_s1_pix  <= '0;
            r_s1_addr <= '0;
        end else begin
            r_s1_vld <= w_acc;
            r_s1_ok  <= w_acc && w_ok;
            r_s1_sof <= w_acc && w_ok && r_first && (r_col == LINE_AW'(2));
            r_s1_eol <= w_acc && w_ok && w_col_last;
            if (w_acc) begin
                r_s1_pix  <= win_elem_t'(pix_data);
                r_s1_addr <= w_addr;
            end
        end
    end

    // Row r-1 comes out of the first buffer and is pushed into the second one step later.
    sobel_line_buf #(.DATA_W(DATA_W), .DEPTH(MAX_LINE), .AW(BUF_AW)) u_buf_r1 (
        .clk       (clk),
        .i_wr_en   (w_acc),
        .i_wr_addr (w_addr),
        .i_wr_data (pix_data),
        .i_rd_en   (w_acc),
        .i_rd_addr (w_addr),
        .o_rd_data (w_row1)
    );

    sobel_line_buf #(.DATA_W(DATA_W), .DEPTH(MAX_LINE), .AW(BUF_AW)) u_buf_r2 (
        .clk       (clk),
        .i_wr_en   (r_s1_vld),
        .i_wr_addr (r_s1_addr),
        .i_wr_data (w_row1),
        .i_rd_en   (w_acc),
        .i_rd_addr (w_addr),
        .o_rd_data (w_row2)
    );

    win_elem_t r_win_a [3];
    win_elem_t r_win_b [3];
    win_elem_t r_win_c [3];
    logic      r_s2_vld, r_s2_sof, r_s2_eol;

    always_ff @(posedge clk) begin
        if (r_s1_vld) begin
            r_win_a <= '{r_win_a[1], r_win_a[2], win_elem_t'(w_row2)};
            r_win_b <= '{r_win_b[1], r_win_b[2], win_elem_t'(w_row1)};
            r_win_c <= '{r_win_c[1], r_win_c[2], r_s1_pix};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || frame_start) begin
            r_s2_vld <= 1'b0;
            r_s2_sof <= 1'b0;
            r_s2_eol <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_ok;
            r_s2_sof <= r_s1_sof;
            r_s2_eol <= r_s1_eol;
        end
    end

    logic signed [MW-1:0] w_a [3];
    logic signed [MW-1:0] w_b [3];
    logic signed [MW-1:0] w_c [3];
    logic signed [MW-1:0] w_gx, w_gy, w_ax, w_ay;
    logic [MW-1:0]        w_mag;
    logic                 w_hit;
    logic [DATA_W-1:0]    w_pix_out;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_a[i] = MW'(r_win_a[i]);
            w_b[i] = MW'(r_win_b[i]);
            w_c[i] = MW'(r_win_c[i]);
        end
        w_gx = (C_SIDE * w_a[2] + C_MID * w_b[2] + C_SIDE * w_c[2])
             - (C_SIDE * w_a[0] + C_MID * w_b[0] + C_SIDE * w_c[0]);
        w_gy = (C_SIDE * w_a[0] + C_MID * w_a[1] + C_SIDE * w_a[2])
             - (C_SIDE * w_c[0] + C_MID * w_c[1] + C_SIDE * w_c[2]);
        w_ax      = w_gx[MW-1] ? -w_gx : w_gx;
        w_ay      = w_gy[MW-1] ? -w_gy : w_gy;
        w_mag     = $unsigned(w_ax) + $unsigned(w_ay);
        w_hit     = w_mag > r_thr;
        w_pix_out = w_hit ? '1 : '0;
    end

`ifdef SOBEL_PACK565_EN
    logic              r_pend_vld, r_pend_eol;
    logic [DATA_W-1:0] r_pend_byte;
    logic [DATA_W-1:0] w_byte0, w_byte1;

    always_comb begin
        w_byte0 = {w_pix_out[7:3], w_pix_out[7:5]};
        w_byte1 = {w_pix_out[4:2], w_pix_out[7:3]};
    end

    // Byte 0 leaves with the normal latency; byte 1 is held for the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || frame_start) begin
            edge_valid  <= 1'b0;
            edge_data   <= '0;
            edge_sof    <= 1'b0;
            edge_eol    <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_eol  <= 1'b0;
            r_pend_byte <= '0;
        end else if (r_s2_vld) begin
            edge_valid  <= 1'b1;
            edge_data   <= w_byte0;
            edge_sof    <= r_s2_sof;
            edge_eol    <= 1'b0;
            r_pend_vld  <= 1'b1;
            r_pend_eol  <= r_s2_eol;
            r_pend_byte <= w_byte1;
        end else if (r_pend_vld) begin
            edge_valid  <= 1'b1;
            edge_data   <= r_pend_byte;
            edge_sof    <= 1'b0;
            edge_eol    <= r_pend_eol;
            r_pend_vld  <= 1'b0;
        end else begin
            edge_valid  <= 1'b0;
            edge_data   <= '0;
            edge_sof    <= 1'b0;
            edge_eol    <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n || frame_start) begin
            edge_valid <= 1'b0;
            edge_data  <= '0;
            edge_sof   <= 1'b0;
            edge_eol   <= 1'b0;
        end else begin
            edge_valid <= r_s2_vld;
            edge_data  <= r_s2_vld ? w_pix_out : '0;
            edge_sof   <= r_s2_sof;
            edge_eol   <= r_s2_eol;
        end
    end
`endif

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Directed, table-driven bench for sobel_edge_stream (default one-word-per-pixel build).
module tb_sobel_edge_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic [11:0] line_len;
    logic [10:0] threshold;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        edge_valid;
    logic [7:0]  edge_data;
    logic        edge_sof;
    logic        edge_eol;
    logic        cfg_err;

    sobel_edge_stream dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .line_len    (line_len),
        .threshold   (threshold),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .edge_valid  (edge_valid),
        .edge_data   (edge_data),
        .edge_sof    (edge_sof),
        .edge_eol    (edge_eol),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       sof;
        logic       eol;
    } cap_t;

    typedef struct {
        string       name;
        int          len;
        int          w;
        int          thr;
        int          pat;
        int          rows;
        int          gap;
        int          exp_err;
        int          exp_cnt;
        int          per;
        logic [63:0] bits;
    } tcase_t;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    cap_t cap_q[$];
    int   lat_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every output and check it lands exactly 3 cycles after its completing pixel.
    always @(posedge clk) begin
        cap_t e;
        int   want;
        #1;
        if (edge_valid) begin
            e.cyc  = cyc;
            e.data = edge_data;
            e.sof  = edge_sof;
            e.eol  = edge_eol;
            cap_q.push_back(e);
            total++;
            if (lat_q.size() == 0) begin
                bad++;
                $display("FAIL latency: got unexpected edge_valid at cycle %0d, expected no output", cyc);
            end else begin
                want = lat_q.pop_front();
                if (want != cyc) begin
                    bad++;
                    $display("FAIL latency: got output at cycle %0d, expected cycle %0d", cyc, want);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by time %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pix_of(input int pat, input int r, input int c);
        case (pat)
            0:       return (c <= 2) ? 8'd0 : 8'd200;
            1:       return 8'd128;
            default: return (r <= 1) ? 8'd0 : 8'd255;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            frame_start = 1'b0;
            pix_valid   = 1'b0;
        end
    endtask

    // A pixel is driven alongside frame_start; it must be dropped.
    task automatic start_frame(input int len, input int thr);
        @(negedge clk);
        frame_start = 1'b1;
        line_len    = 12'(len);
        threshold   = 11'(thr);
        pix_valid   = 1'b1;
        pix_data    = 8'hFF;
        lat_q.delete();
        cap_q.delete();
    endtask

    task automatic send_pix(input int pat, input int r, input int c);
        @(negedge clk);
        frame_start = 1'b0;
        pix_valid   = 1'b1;
        pix_data    = pix_of(pat, r, c);
        if (r >= 2 && c >= 2) lat_q.push_back(cyc + 3);
    endtask

    task automatic run_frame(input tcase_t t);
        start_frame(t.len, t.thr);
        for (int r = 0; r < t.rows; r++) begin
            for (int c = 0; c < t.w; c++) begin
                send_pix(t.pat, r, c);
                if (t.gap > 1) idle(t.gap - 1);
            end
        end
        idle(8);
    endtask

    task automatic check_outputs(input string nm, input int exp_cnt, input logic [63:0] bits,
                                 input int per);
        chk($sformatf("%s count", nm), cap_q.size(), exp_cnt);
        for (int n = 0; n < cap_q.size() && n < exp_cnt; n++) begin
            chk($sformatf("%s[%0d] data", nm, n), int'(cap_q[n].data), bits[n] ? 255 : 0);
            chk($sformatf("%s[%0d] sof", nm, n), int'(cap_q[n].sof), (n == 0) ? 1 : 0);
            chk($sformatf("%s[%0d] eol", nm, n), int'(cap_q[n].eol), (((n + 1) % per) == 0) ? 1 : 0);
        end
        chk($sformatf("%s missing", nm), lat_q.size(), 0);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, " edge_valid"}, int'(edge_valid), 0);
        chk({nm, " edge_data"},  int'(edge_data), 0);
        chk({nm, " edge_sof"},   int'(edge_sof), 0);
        chk({nm, " edge_eol"},   int'(edge_eol), 0);
        chk({nm, " cfg_err"},    int'(cfg_err), 0);
    endtask

    tcase_t tc [11];

    initial begin
        tc[0]  = '{"vstep",        6,    6,    100, 0, 4, 1, 0, 8,  4,  64'h66};
        tc[1]  = '{"vstep_thr800", 6,    6,    800, 0, 3, 1, 0, 4,  4,  64'h0};
        tc[2]  = '{"vstep_thr799", 6,    6,    799, 0, 3, 1, 0, 4,  4,  64'h6};
        tc[3]  = '{"flat",         16,   16,   0,   1, 4, 1, 0, 28, 14, 64'h0};
        tc[4]  = '{"len1",         1,    3,    500, 2, 4, 1, 1, 2,  1,  64'h3};
        tc[5]  = '{"hstep",        8,    8,    500, 2, 5, 1, 0, 18, 6,  64'hFFF};
        tc[6]  = '{"hstep_gap3",   8,    8,    500, 2, 4, 3, 0, 12, 6,  64'hFFF};
        tc[7]  = '{"len2",         2,    3,    0,   1, 0, 1, 1, 0,  1,  64'h0};
        tc[8]  = '{"len2049",      2049, 2048, 0,   1, 0, 1, 1, 0,  1,  64'h0};
        tc[9]  = '{"len2048",      2048, 2048, 0,   1, 0, 1, 0, 0,  1,  64'h0};
        tc[10] = '{"len3_flat",    3,    3,    0,   1, 3, 1, 0, 1,  1,  64'h0};

        rst_n       = 1'b0;
        frame_start = 1'b0;
        line_len    = '0;
        threshold   = '0;
        pix_valid   = 1'b0;
        pix_data    = '0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 11; i++) begin
            run_frame(tc[i]);
            chk({tc[i].name, " cfg_err"}, int'(cfg_err), tc[i].exp_err);
            check_outputs(tc[i].name, tc[i].exp_cnt, tc[i].bits, tc[i].per);
        end

        // Abort part-way through row 3, then a fresh frame must start cleanly.
        start_frame(6, 100);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 6; c++) send_pix(0, r, c);
        for (int c = 0; c < 3; c++) send_pix(0, 3, c);
        start_frame(6, 100);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 6; c++) send_pix(0, r, c);
        idle(5);
        chk("abort quiet", cap_q.size(), 0);
        for (int r = 2; r < 4; r++)
            for (int c = 0; c < 6; c++) send_pix(0, r, c);
        idle(8);
        check_outputs("abort_new", 8, 64'h66, 4);

        // Reset one cycle before an edge pixel would leave the pipeline.
        start_frame(1, 500);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++) send_pix(2, r, c);
        for (int c = 0; c < 3; c++) send_pix(2, 2, c);
        idle(1);
        @(negedge clk);
        rst_n     = 1'b0;
        pix_valid = 1'b1;
        pix_data  = 8'hFF;
        lat_q.delete();
        @(posedge clk);
        #1;
        chk_outputs_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        cap_q.delete();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_data  = (i < 6) ? 8'd0 : 8'd255;
        end
        idle(8);
        chk("idle pixels ignored", cap_q.size(), 0);
        chk("idle cfg_err", int'(cfg_err), 0);

        run_frame(tc[0]);
        check_outputs("after_reset", 8, 64'h66, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
